// File: rtl/team_06_echo_mem_sched.sv
// Echo delay-line sequencer: writes each accepted sample into a circular SRAM buffer,
// then reads back the sample `offset` positions earlier once enough history exists.
module team_06_echo_mem_sched #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              echo_on,
    input  logic [ADDR_W-1:0] offset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] past_sample,
    output logic              search_enable,
    output logic              busy,
    output logic              sample_done,
    output logic              overrun
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   fill_cnt_q, fill_cnt_d;
    logic [ADDR_W-1:0]   offset_q, offset_d;
    logic                echo_on_q, echo_on_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   past_sample_q, past_sample_d;
    logic                search_enable_q, search_enable_d;
    logic                busy_q, busy_d;
    logic                sample_done_q, sample_done_d;
    logic                overrun_q, overrun_d;

    logic                ack;
    logic [ADDR_W-1:0]   rd_addr;
    logic [ADDR_W-1:0]   fill_inc;
    logic                hist_ok;

    assign ack      = mem_req_q & mem_ack;
    assign rd_addr  = ADDR_W'(wr_ptr_q - offset_q);
    assign fill_inc = (fill_cnt_q == {ADDR_W{1'b1}}) ? fill_cnt_q : ADDR_W'(fill_cnt_q + ADDR_W'(1));
    // Read only when the requested delay is already covered by stored history
    assign hist_ok  = echo_on_q && (offset_q != '0) && (fill_inc > offset_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            wr_ptr_q        <= '0;
            fill_cnt_q      <= '0;
            offset_q        <= '0;
            echo_on_q       <= 1'b0;
            mem_req_q       <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            past_sample_q   <= '0;
            search_enable_q <= 1'b0;
            busy_q          <= 1'b0;
            sample_done_q   <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            fill_cnt_q      <= fill_cnt_d;
            offset_q        <= offset_d;
            echo_on_q       <= echo_on_d;
            mem_req_q       <= mem_req_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            past_sample_q   <= past_sample_d;
            search_enable_q <= search_enable_d;
            busy_q          <= busy_d;
            sample_done_q   <= sample_done_d;
            overrun_q       <= overrun_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        wr_ptr_d        = wr_ptr_q;
        fill_cnt_d      = fill_cnt_q;
        offset_d        = offset_q;
        echo_on_d       = echo_on_q;
        mem_req_d       = mem_req_q;
        mem_we_d        = mem_we_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        past_sample_d   = past_sample_q;
        search_enable_d = search_enable_q;
        busy_d          = busy_q;
        sample_done_d   = 1'b0;
        overrun_d       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (sample_valid) begin
                    offset_d    = offset;
                    echo_on_d   = echo_on;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = wr_ptr_q;
                    mem_wdata_d = sample_in;
                    busy_d      = 1'b1;
                    state_d     = ST_WR;
                end
            end
            ST_WR: begin
                if (ack) begin
                    wr_ptr_d   = ADDR_W'(wr_ptr_q + ADDR_W'(1));
                    fill_cnt_d = fill_inc;
                    if (hist_ok) begin
                        mem_we_d   = 1'b0;
                        mem_addr_d = rd_addr;
                        state_d    = ST_RD;
                    end else begin
                        mem_req_d       = 1'b0;
                        search_enable_d = 1'b0;
                        sample_done_d   = 1'b1;
                        state_d         = ST_DONE;
                    end
                end
            end
            ST_RD: begin
                if (ack) begin
                    mem_req_d       = 1'b0;
                    past_sample_d   = mem_rdata;
                    search_enable_d = 1'b1;
                    sample_done_d   = 1'b1;
                    state_d         = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Any strobe outside IDLE is dropped
        if (sample_valid && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign past_sample   = past_sample_q;
    assign search_enable = search_enable_q;
    assign busy          = busy_q;
    assign sample_done   = sample_done_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_team_06_echo_mem_sched.sv
// Directed bench for the echo SRAM sequencer with a behavioural SRAM that inserts
// a programmable number of wait cycles per transaction.
module tb_team_06_echo_mem_sched;

    localparam int unsigned ADDR_W = 13;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              sample_valid;
    logic [DATA_W-1:0] sample_in;
    logic              echo_on;
    logic [ADDR_W-1:0] offset;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] past_sample;
    logic              search_enable;
    logic              busy;
    logic              sample_done;
    logic              overrun;

    team_06_echo_mem_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .sample_valid(sample_valid), .sample_in(sample_in),
        .echo_on(echo_on), .offset(offset),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .past_sample(past_sample), .search_enable(search_enable),
        .busy(busy), .sample_done(sample_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM with wait states and bus-stability monitor
    logic [DATA_W-1:0] mem [DEPTH];
    int                wait_cfg = 0;
    int                wcnt;
    int                n_reads = 0;
    int                n_stab_viol = 0;
    logic [ADDR_W-1:0] last_wr_addr, last_rd_addr;
    logic              hold_q;
    logic [ADDR_W-1:0] prev_addr;
    logic [DATA_W-1:0] prev_wdata;
    logic              prev_we;

    assign mem_ack   = mem_req && (wcnt == wait_cfg);
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt   <= 0;
            hold_q <= 1'b0;
        end else begin
            if (hold_q && mem_req &&
                (mem_addr != prev_addr || mem_wdata != prev_wdata || mem_we != prev_we))
                n_stab_viol <= n_stab_viol + 1;
            hold_q     <= mem_req && !mem_ack;
            prev_addr  <= mem_addr;
            prev_wdata <= mem_wdata;
            prev_we    <= mem_we;
            if (mem_req && mem_ack) begin
                wcnt <= 0;
                if (mem_we) begin
                    mem[mem_addr] <= mem_wdata;
                    last_wr_addr  <= mem_addr;
                end else begin
                    n_reads      <= n_reads + 1;
                    last_rd_addr <= mem_addr;
                end
            end else if (mem_req) begin
                wcnt <= wcnt + 1;
            end else begin
                wcnt <= 0;
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobe one sample, scramble offset afterwards, wait for DONE, return latency
    task automatic do_sample(input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] off,
                             input logic eo, output int lat);
        sample_valid = 1'b1;
        sample_in    = d;
        offset       = off;
        echo_on      = eo;
        tick();
        sample_valid = 1'b0;
        offset       = '0;
        lat          = 1;
        while (!sample_done && lat < 60) begin
            tick();
            lat++;
        end
        if (!sample_done) check("done_timeout", 32'(sample_done), 32'd1);
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    int lat;
    int reads0;

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;
        sample_valid = 1'b0;
        sample_in    = '0;
        echo_on      = 1'b0;
        offset       = '0;
        do_reset();

        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_outs", {28'd0, search_enable, sample_done, overrun, |past_sample}, 32'd0);

        // Fill gate: offset 3, samples 10..40
        do_sample(8'd10, 13'd3, 1'b1, lat);
        check("fill1_lat", 32'(lat), 32'd2);
        check("fill1_se", 32'(search_enable), 32'd0);
        do_sample(8'd20, 13'd3, 1'b1, lat);
        check("fill2_se", 32'(search_enable), 32'd0);
        do_sample(8'd30, 13'd3, 1'b1, lat);
        check("fill3_se", 32'(search_enable), 32'd0);
        check("fill3_noread", 32'(n_reads), 32'd0);
        do_sample(8'd40, 13'd3, 1'b1, lat);
        check("fill4_lat", 32'(lat), 32'd3);
        check("fill4_rdaddr", 32'(last_rd_addr), 32'd0);
        check("fill4_past", 32'(past_sample), 32'd10);
        check("fill4_se", 32'(search_enable), 32'd1);
        check("fill4_busy", 32'(busy), 32'd0);

        // Two wait cycles per transaction: write at 4, read at 1
        wait_cfg = 2;
        do_sample(8'd50, 13'd3, 1'b1, lat);
        check("wait_lat", 32'(lat), 32'd7);
        check("wait_past", 32'(past_sample), 32'd20);
        check("wait_mem4", 32'(mem[4]), 32'd50);
        check("stable_bus", 32'(n_stab_viol), 32'd0);
        wait_cfg = 0;

        // Overrun: second strobe one cycle after the first
        sample_valid = 1'b1;
        sample_in    = 8'd77;
        offset       = 13'd3;
        echo_on      = 1'b1;
        tick();
        sample_in    = 8'd99;
        check("ovr_before", 32'(overrun), 32'd0);
        tick();
        sample_valid = 1'b0;
        check("ovr_pulse", 32'(overrun), 32'd1);
        tick();
        check("ovr_clear", 32'(overrun), 32'd0);
        check("ovr_done", 32'(sample_done), 32'd1);
        tick();
        check("ovr_mem5", 32'(mem[5]), 32'd77);
        check("ovr_past", 32'(past_sample), 32'd30);

        // echo_on=0: write only at 6, past held
        reads0 = n_reads;
        do_sample(8'd88, 13'd1, 1'b0, lat);
        check("eoff_wraddr", 32'(last_wr_addr), 32'd6);
        check("eoff_noread", 32'(n_reads), 32'(reads0));
        check("eoff_se", 32'(search_enable), 32'd0);
        check("eoff_past", 32'(past_sample), 32'd30);

        // offset=0: no read
        do_sample(8'd66, 13'd0, 1'b1, lat);
        check("off0_noread", 32'(n_reads), 32'(reads0));
        check("off0_se", 32'(search_enable), 32'd0);
        check("off0_past", 32'(past_sample), 32'd30);
        check("off0_lat", 32'(lat), 32'd2);

        // Reset while the read is waiting on the SRAM
        wait_cfg     = 3;
        sample_valid = 1'b1;
        sample_in    = 8'h55;
        offset       = 13'd1;
        echo_on      = 1'b1;
        tick();
        sample_valid = 1'b0;
        repeat (4) tick();
        check("rdwait_inflight", {30'd0, mem_req, mem_we}, 32'd2);
        rst = 1'b1;
        #1;
        check("rstmid_req", 32'(mem_req), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_se", 32'(search_enable), 32'd0);
        tick();
        rst = 1'b0;
        wait_cfg = 0;
        tick();
        do_sample(8'h11, 13'd1, 1'b1, lat);
        check("post_rst_wraddr", 32'(last_wr_addr), 32'd0);
        check("post_rst_se", 32'(search_enable), 32'd0);
        check("post_rst_lat", 32'(lat), 32'd2);

        // Wrap: preload 8190 samples with echo off, then offset 4
        do_reset();
        for (int i = 0; i < 8190; i++) do_sample(DATA_W'(i), 13'd1, 1'b0, lat);
        check("preload_wraddr", 32'(last_wr_addr), 32'd8189);
        do_sample(8'hA1, 13'd4, 1'b1, lat);
        check("wrapA_wr", 32'(last_wr_addr), 32'd8190);
        check("wrapA_rd", 32'(last_rd_addr), 32'd8186);
        check("wrapA_past", 32'(past_sample), 32'd250);
        do_sample(8'hB2, 13'd4, 1'b1, lat);
        check("wrapB_wr", 32'(last_wr_addr), 32'd8191);
        check("wrapB_rd", 32'(last_rd_addr), 32'd8187);
        check("wrapB_past", 32'(past_sample), 32'd251);
        do_sample(8'hC3, 13'd4, 1'b1, lat);
        check("wrapC_wr", 32'(last_wr_addr), 32'd0);
        check("wrapC_rd", 32'(last_rd_addr), 32'd8188);
        check("wrapC_past", 32'(past_sample), 32'd252);
        check("wrapC_se", 32'(search_enable), 32'd1);
        check("wrap_mem0", 32'(mem[0]), 32'hC3);
        check("final_stable_bus", 32'(n_stab_viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
